// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the input debounce stage: the per-channel FSM
//   state encoding, the legal range of the qualification length, and the
//   helper that sizes the qualification counter.
package debounce_pkg;

  // Two stable states and two qualifying states. The encoding is fixed so
  // that bit 1 reads as the accepted level of a stable state.
  typedef enum logic [1:0] {
    LOW      = 2'b00,
    CHK_HIGH = 2'b01,
    HIGH     = 2'b10,
    CHK_LOW  = 2'b11
  } state_e;

  localparam int STABLE_MIN = 2;
  localparam int STABLE_MAX = 255;

  // Counter must be able to represent STABLE_CYCLES itself, so it is sized
  // for STABLE_CYCLES+1 distinct values.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One input channel: two-flop synchronizer, saturating qualification
//   counter and a four-state debounce FSM. All outputs are registered.
//
// Ports
//   clk      : sole clock
//   rst_n    : asynchronous active-low reset
//   i_raw    : asynchronous pad input
//   o_clean  : debounced level
//   o_rise   : one-cycle pulse when o_clean goes 0->1
//   o_fall   : one-cycle pulse when o_clean goes 1->0
//
// state    | meaning
// ---------+-------------------------------------------------------------
// LOW      | accepted level is 0, synchronized input also 0
// CHK_HIGH | accepted level is 0, counting consecutive 1 samples
// HIGH     | accepted level is 1, synchronized input also 1
// CHK_LOW  | accepted level is 1, counting consecutive 0 samples
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic          r_s1;
  logic          r_s2;
  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_clean;
  logic          r_rise;
  logic          r_fall;

  state_e        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_term;
  logic          w_clean_nxt;
  logic          w_rise_nxt;
  logic          w_fall_nxt;

  // Synchronizer: r_s2 is the only sample the FSM ever looks at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // The terminal compare fires before the counter could ever reach its
  // maximum, so saturation only guards against an illegal state.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
  assign w_term    = (r_cnt == CNT_TERM);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;

    case (r_state)
      LOW: begin
        if (r_s2) begin
          w_state_nxt = CHK_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = CNT_ZERO;
        end
      end

      CHK_HIGH: begin
        if (!r_s2) begin
          // Bounce: abandon the check, accepted level stays 0.
          w_state_nxt = LOW;
          w_cnt_nxt   = CNT_ZERO;
        end else if (w_term) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = CNT_ZERO;
          w_clean_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end

      HIGH: begin
        if (!r_s2) begin
          w_state_nxt = CHK_LOW;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = CNT_ZERO;
        end
      end

      CHK_LOW: begin
        if (r_s2) begin
          // Bounce: abandon the check, accepted level stays 1.
          w_state_nxt = HIGH;
          w_cnt_nxt   = CNT_ZERO;
        end else if (w_term) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = CNT_ZERO;
          w_clean_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end

      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = CNT_ZERO;
        w_clean_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOW;
      r_cnt   <= CNT_ZERO;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/input_debounce_stage.sv
// input_debounce_stage
//   Conditions raw pad inputs before they reach the project's gate logic.
//   Each bit gets its own synchronizer and debounce FSM; channels share no
//   state. clean feeds the downstream NOR stage directly, rise/fall are
//   single-cycle edge pulses for counters or latches.
//
// Parameters
//   WIDTH         : number of independent channels
//   STABLE_CYCLES : consecutive synchronized samples needed to accept a
//                   level change (legal range 2..255)
//
// Ports
//   clk     : sole clock
//   rst_n   : asynchronous active-low reset
//   raw_in  : asynchronous pad inputs (io_in[3:2] in the user project)
//   clean   : debounced level, registered
//   rise    : one-cycle pulse when clean goes 0->1
//   fall    : one-cycle pulse when clean goes 1->0
module input_debounce_stage
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] w_clean;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_channel (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (raw_in[gi]),
      .o_clean (w_clean[gi]),
      .o_rise  (w_rise[gi]),
      .o_fall  (w_fall[gi])
    );
  end

  // Straight wiring: the channel outputs are already registered, so the
  // NOR stage sees clean with no additional delay.
  assign clean = w_clean;
  assign rise  = w_rise;
  assign fall  = w_fall;

endmodule

// File: tb/tb_input_debounce_stage.sv
module tb_input_debounce_stage;

  logic       clk;
  logic       rst_n;
  logic [1:0] raw_in;
  logic [1:0] clean;
  logic [1:0] rise;
  logic [1:0] fall;

  input_debounce_stage #(
    .WIDTH         (2),
    .STABLE_CYCLES (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (raw_in),
    .clean  (clean),
    .rise   (rise),
    .fall   (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         edge_n;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] clean;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic [1:0] exp_clean = 2'b00;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, req, edge_cnt);
  endtask

  // Expected event after edge (edge_cnt + ofs); offsets are hand-computed.
  task automatic expect_evt(input int ofs, input logic [1:0] r,
                            input logic [1:0] f, input logic [1:0] c);
    exp_t e;
    e.edge_n = edge_cnt + ofs;
    e.rise   = r;
    e.fall   = f;
    e.clean  = c;
    q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops an expectation whenever a pulse appears, otherwise checks
  // that clean holds its last accepted value.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset_outputs", int'({clean, rise, fall}), 0);
      exp_clean = 2'b00;
    end else if ((rise | fall) != 2'b00) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", int'({rise, fall}), 0);
      end else begin
        e = q.pop_front();
        chk("pulse_edge",  edge_cnt,    e.edge_n);
        chk("pulse_rise",  int'(rise),  int'(e.rise));
        chk("pulse_fall",  int'(fall),  int'(e.fall));
        chk("pulse_clean", int'(clean), int'(e.clean));
        exp_clean = e.clean;
      end
    end else begin
      chk("clean_hold", int'(clean), int'(exp_clean));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b1;
    raw_in = 2'b11;
    #2 rst_n = 1'b0;
    cycles(5);

    // Reset with inputs high, then release: both channels qualify.
    rst_n = 1'b1;
    expect_evt(10, 2'b11, 2'b00, 2'b11);
    cycles(15);
    raw_in = 2'b00;
    expect_evt(10, 2'b00, 2'b11, 2'b00);
    cycles(15);

    // Glitch filter: 7-cycle pulse on ch0 is rejected.
    raw_in = 2'b01;
    cycles(7);
    raw_in = 2'b00;
    cycles(15);

    // Clean toggle on ch1.
    raw_in = 2'b10;
    expect_evt(10, 2'b10, 2'b00, 2'b10);
    cycles(20);
    raw_in = 2'b00;
    expect_evt(10, 2'b00, 2'b10, 2'b00);
    cycles(15);

    // Bounce during check on ch0.
    raw_in = 2'b01;
    cycles(5);
    raw_in = 2'b00;
    cycles(1);
    raw_in = 2'b01;
    expect_evt(10, 2'b01, 2'b00, 2'b01);
    cycles(15);
    raw_in = 2'b00;
    expect_evt(10, 2'b00, 2'b01, 2'b00);
    cycles(15);

    // Reset mid-check on ch0.
    raw_in = 2'b01;
    cycles(6);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    expect_evt(10, 2'b01, 2'b00, 2'b01);
    cycles(15);
    raw_in = 2'b00;
    expect_evt(10, 2'b00, 2'b01, 2'b00);
    cycles(15);

    // Independence: ch0 toggles every 3 cycles while ch1 steps cleanly.
    raw_in = 2'b10;
    expect_evt(10, 2'b10, 2'b00, 2'b10);
    for (int i = 0; i < 8; i++) begin
      cycles(3);
      raw_in[0] = ~raw_in[0];
    end
    raw_in = 2'b00;
    expect_evt(10, 2'b00, 2'b10, 2'b00);
    cycles(15);

    chk("pending_expectations", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
